// File: rtl/kfps2kb_queue.sv
// kfps2kb_queue: PS/2 keyboard front end with a keycode FIFO.
// Decodes set-2 prefixes (F0 break, E0 extended, E1 pause) and translates
// codes to PC/XT set 1. Results are queued so the host side can drain
// several codes per interrupt.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-low reset
//   rx_data        received byte from the PS/2 shift register
//   rx_valid       one-cycle strobe, rx_data valid
//   rx_error       one-cycle strobe, parity/framing/timeout error
//   pop            consume the head entry (ignored while irq=0)
//   clear_overflow clears the sticky overflow flag
//   irq            FIFO not empty
//   keycode        head entry, 00 when empty
//   count          FIFO occupancy
//   overflow       sticky, set whenever a code is lost
module kfps2kb_queue #(
    parameter int DEPTH           = 16,
    parameter bit TRANSLATE       = 1'b1,
    parameter bit DROP_FAKE_SHIFT = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_error,
    input  logic                       pop,
    input  logic                       clear_overflow,
    output logic                       irq,
    output logic [7:0]                 keycode,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Set-2 to set-1 translation for codes 00..7F.
    localparam logic [7:0] XT_MAP [0:127] = '{
        8'hff, 8'h43, 8'h41, 8'h3f, 8'h3d, 8'h3b, 8'h3c, 8'h58, 8'h64, 8'h44, 8'h42, 8'h40, 8'h3e, 8'h0f, 8'h29, 8'h59,
        8'h65, 8'h38, 8'h2a, 8'h70, 8'h1d, 8'h10, 8'h02, 8'h5a, 8'h66, 8'h71, 8'h2c, 8'h1f, 8'h1e, 8'h11, 8'h03, 8'h5b,
        8'h67, 8'h2e, 8'h2d, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5c, 8'h68, 8'h39, 8'h2f, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5d,
        8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5e, 8'h6a, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5f,
        8'h6b, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0b, 8'h0a, 8'h60, 8'h6c, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0c, 8'h61,
        8'h6d, 8'h73, 8'h28, 8'h74, 8'h1a, 8'h0d, 8'h62, 8'h6e, 8'h3a, 8'h36, 8'h1c, 8'h1b, 8'h75, 8'h2b, 8'h63, 8'h76,
        8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h0e, 8'h7b, 8'h7c, 8'h4f, 8'h7d, 8'h4b, 8'h47, 8'h7e, 8'h7f, 8'h6f,
        8'h52, 8'h53, 8'h50, 8'h4c, 8'h4d, 8'h48, 8'h01, 8'h45, 8'h57, 8'h4e, 8'h51, 8'h4a, 8'h37, 8'h49, 8'h46, 8'h54
    };

    // Only 83 (F7) is remapped in the upper half; everything else passes.
    function automatic logic [7:0] xlate(input logic [7:0] c);
        logic [7:0] r;
        if (c[7]) r = (c == 8'h83) ? 8'h41 : c;
        else      r = XT_MAP[c[6:0]];
        return r;
    endfunction

    typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, EMIT} state_t;

    state_t        state, state_n;
    logic [7:0]    emit_code, emit_code_n;
    logic          push_req;
    logic [7:0]    push_data;
    logic          strobe_lost;

    // ---------------- decoder ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            emit_code <= 8'h00;
        end else begin
            state     <= state_n;
            emit_code <= emit_code_n;
        end
    end

    always_comb begin
        state_n     = state;
        emit_code_n = emit_code;
        push_req    = 1'b0;
        push_data   = 8'h00;
        strobe_lost = 1'b0;
        if (state == EMIT) begin
            // The second half of an E0 pair owns the push slot; any strobe
            // landing here cannot be queued and counts as lost.
            push_req    = 1'b1;
            push_data   = emit_code;
            state_n     = IDLE;
            strobe_lost = rx_valid | rx_error;
        end else if (rx_error) begin
            push_req  = 1'b1;
            push_data = 8'hff;
            state_n   = IDLE;
        end else if (rx_valid) begin
            if (!TRANSLATE) begin
                push_req  = (rx_data != 8'hfa);
                push_data = rx_data;
            end else if (rx_data == 8'hfa || rx_data == 8'hee) begin
                // acknowledge / echo: dropped, prefix state kept
            end else if (rx_data == 8'h00 || rx_data == 8'hff) begin
                push_req  = 1'b1;
                push_data = 8'hff;
                state_n   = IDLE;
            end else if (rx_data == 8'hf0) begin
                if (state == EXT)       state_n = EXT_BRK;
                else if (state == IDLE) state_n = BRK;
            end else if (rx_data == 8'he0) begin
                state_n = EXT;
            end else if (rx_data == 8'he1) begin
                push_req  = 1'b1;
                push_data = 8'he1;
                state_n   = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        push_req  = 1'b1;
                        push_data = xlate(rx_data);
                    end
                    BRK: begin
                        push_req  = 1'b1;
                        push_data = xlate(rx_data) | 8'h80;
                        state_n   = IDLE;
                    end
                    default: begin
                        // EXT / EXT_BRK. E0 12 / E0 59 are the fake shifts
                        // some keyboards wrap around extended keys.
                        if (DROP_FAKE_SHIFT && (rx_data == 8'h12 || rx_data == 8'h59)) begin
                            state_n = IDLE;
                        end else begin
                            push_req    = 1'b1;
                            push_data   = 8'he0;
                            emit_code_n = xlate(rx_data) | ((state == EXT_BRK) ? 8'h80 : 8'h00);
                            state_n     = EMIT;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CW-1:0] cnt_n;
    logic [7:0]    head_n;
    logic          do_pop, do_push, ovf_set;

    always_comb begin
        do_pop  = pop & irq;
        // Full FIFO still accepts a push when the head is popped together.
        do_push = push_req & ((count != FULL) | do_pop);
        ovf_set = (push_req & ~do_push) | strobe_lost;
        rd_n    = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
        wr_n    = do_push ? wr_ptr + 1'b1 : wr_ptr;
        cnt_n   = count;
        if (do_push && !do_pop)      cnt_n = count + 1'b1;
        else if (!do_push && do_pop) cnt_n = count - 1'b1;
        // New head may be the entry written this very cycle: bypass it.
        if (cnt_n == '0)                     head_n = 8'h00;
        else if (do_push && wr_ptr == rd_n)  head_n = push_data;
        else                                 head_n = mem[rd_n];
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            irq      <= 1'b0;
            keycode  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            rd_ptr  <= rd_n;
            wr_ptr  <= wr_n;
            count   <= cnt_n;
            irq     <= (cnt_n != '0);
            keycode <= head_n;
            if (ovf_set)             overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kfps2kb_queue.sv
// Directed bench for kfps2kb_queue: a translating instance (dut0) and a
// raw pass-through instance (dut1), both DEPTH=8.
module tb_kfps2kb_queue;

    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] rx_data0 = 8'h00, rx_data1 = 8'h00;
    logic       rx_valid0 = 1'b0, rx_valid1 = 1'b0;
    logic       rx_error0 = 1'b0, rx_error1 = 1'b0;
    logic       pop0 = 1'b0, pop1 = 1'b0;
    logic       clr0 = 1'b0, clr1 = 1'b0;
    logic       irq0, irq1, overflow0, overflow1;
    logic [7:0] keycode0, keycode1;
    logic [3:0] count0, count1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    kfps2kb_queue #(.DEPTH(DEPTH), .TRANSLATE(1'b1), .DROP_FAKE_SHIFT(1'b1)) dut0 (
        .clock(clock), .reset(reset), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_error(rx_error0), .pop(pop0), .clear_overflow(clr0),
        .irq(irq0), .keycode(keycode0), .count(count0), .overflow(overflow0)
    );

    kfps2kb_queue #(.DEPTH(DEPTH), .TRANSLATE(1'b0), .DROP_FAKE_SHIFT(1'b1)) dut1 (
        .clock(clock), .reset(reset), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_error(rx_error1), .pop(pop1), .clear_overflow(clr1),
        .irq(irq1), .keycode(keycode1), .count(count1), .overflow(overflow1)
    );

    // Stimulus helpers (all start and end on a falling edge).
    task automatic send0(input logic [7:0] b);
        rx_data0 = b; rx_valid0 = 1'b1;
        @(negedge clock); rx_valid0 = 1'b0;
        @(negedge clock);
    endtask

    task automatic send1(input logic [7:0] b);
        rx_data1 = b; rx_valid1 = 1'b1;
        @(negedge clock); rx_valid1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic err0();
        rx_error0 = 1'b1;
        @(negedge clock); rx_error0 = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_pop0();
        pop0 = 1'b1; @(negedge clock); pop0 = 1'b0;
    endtask

    task automatic pulse_pop1();
        pop1 = 1'b1; @(negedge clock); pop1 = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({irq0, keycode0, count0, overflow0} !== {1'b0, 8'h00, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset0: irq=%b key=%h cnt=%0d ovf=%b, want 0/00/0/0", irq0, keycode0, count0, overflow0);
        end
        vectors++;
        if ({irq1, keycode1, count1, overflow1} !== {1'b0, 8'h00, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset1: irq=%b key=%h cnt=%0d ovf=%b, want 0/00/0/0", irq1, keycode1, count1, overflow1);
        end
    endtask

    task automatic test_make_break();
        logic [7:0] exp [2] = '{8'h1e, 8'h9e};
        send0(8'h1c); send0(8'hf0); send0(8'h1c);
        vectors++;
        if (count0 !== 4'd2 || irq0 !== 1'b1) begin
            miscompares++;
            $display("FAIL mb_count: cnt=%0d irq=%b, want 2/1", count0, irq0);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (keycode0 !== exp[i]) begin
                miscompares++;
                $display("FAIL mb_entry%0d: got %h, want %h", i, keycode0, exp[i]);
            end
            pulse_pop0();
        end
        vectors++;
        if (keycode0 !== 8'h00 || irq0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mb_empty: key=%h irq=%b, want 00/0", keycode0, irq0);
        end
    endtask

    task automatic test_extended();
        logic [7:0] exp [4] = '{8'he0, 8'h48, 8'he0, 8'hc8};
        logic [7:0] pz  [6] = '{8'he1, 8'h1d, 8'h45, 8'he1, 8'h9d, 8'hc5};
        send0(8'he0);
        vectors++;
        if (count0 !== 4'd0) begin
            miscompares++;
            $display("FAIL ext_prefix: cnt=%0d, want 0", count0);
        end
        // E0 visible one cycle after the strobe, the code one cycle later.
        rx_data0 = 8'h75; rx_valid0 = 1'b1;
        @(negedge clock); rx_valid0 = 1'b0;
        vectors++;
        if (count0 !== 4'd1 || keycode0 !== 8'he0) begin
            miscompares++;
            $display("FAIL ext_lat1: cnt=%0d key=%h, want 1/e0", count0, keycode0);
        end
        @(negedge clock);
        vectors++;
        if (count0 !== 4'd2) begin
            miscompares++;
            $display("FAIL ext_lat2: cnt=%0d, want 2", count0);
        end
        send0(8'he0); send0(8'hf0); send0(8'h75);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (keycode0 !== exp[i]) begin
                miscompares++;
                $display("FAIL ext_entry%0d: got %h, want %h", i, keycode0, exp[i]);
            end
            pulse_pop0();
        end
        // Fake shifts vanish completely.
        send0(8'he0); send0(8'h12);
        send0(8'he0); send0(8'hf0); send0(8'h59);
        vectors++;
        if (count0 !== 4'd0) begin
            miscompares++;
            $display("FAIL fake_shift: cnt=%0d, want 0", count0);
        end
        send0(8'h1c);
        vectors++;
        if (count0 !== 4'd1 || keycode0 !== 8'h1e) begin
            miscompares++;
            $display("FAIL fake_after: cnt=%0d key=%h, want 1/1e", count0, keycode0);
        end
        pulse_pop0();
        // Pause key.
        send0(8'he1); send0(8'h14); send0(8'h77);
        send0(8'he1); send0(8'hf0); send0(8'h14); send0(8'hf0); send0(8'h77);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (keycode0 !== pz[i]) begin
                miscompares++;
                $display("FAIL pause%0d: got %h, want %h", i, keycode0, pz[i]);
            end
            pulse_pop0();
        end
    endtask

    task automatic test_filter_errors();
        send0(8'hfa);
        vectors++;
        if (count0 !== 4'd0) begin
            miscompares++;
            $display("FAIL filter_fa: cnt=%0d, want 0", count0);
        end
        err0();
        send0(8'he0); err0();
        // error and valid together: only the error counts
        rx_data0 = 8'h1c; rx_valid0 = 1'b1; rx_error0 = 1'b1;
        @(negedge clock); rx_valid0 = 1'b0; rx_error0 = 1'b0;
        @(negedge clock);
        send0(8'h00);
        vectors++;
        if (count0 !== 4'd4) begin
            miscompares++;
            $display("FAIL err_count: cnt=%0d, want 4", count0);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (keycode0 !== 8'hff) begin
                miscompares++;
                $display("FAIL err_entry%0d: got %h, want ff", i, keycode0);
            end
            pulse_pop0();
        end
        // push with pop on an empty FIFO: pop ignored, push lands
        rx_data0 = 8'h1c; rx_valid0 = 1'b1; pop0 = 1'b1;
        @(negedge clock); rx_valid0 = 1'b0; pop0 = 1'b0;
        vectors++;
        if (count0 !== 4'd1 || keycode0 !== 8'h1e) begin
            miscompares++;
            $display("FAIL empty_pushpop: cnt=%0d key=%h, want 1/1e", count0, keycode0);
        end
        pulse_pop0();
    endtask

    task automatic test_overflow_wrap();
        logic [7:0] mk  [9] = '{8'h16, 8'h1e, 8'h26, 8'h25, 8'h2e, 8'h36, 8'h3d, 8'h3e, 8'h46};
        logic [7:0] exp [8] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0b};
        for (int i = 0; i < 8; i++) send0(mk[i]);
        vectors++;
        if (count0 !== 4'd8 || overflow0 !== 1'b0) begin
            miscompares++;
            $display("FAIL full: cnt=%0d ovf=%b, want 8/0", count0, overflow0);
        end
        send0(mk[8]);
        vectors++;
        if (count0 !== 4'd8 || overflow0 !== 1'b1 || keycode0 !== 8'h02) begin
            miscompares++;
            $display("FAIL overflow: cnt=%0d ovf=%b key=%h, want 8/1/02", count0, overflow0, keycode0);
        end
        rx_data0 = 8'h45; rx_valid0 = 1'b1; pop0 = 1'b1;
        @(negedge clock); rx_valid0 = 1'b0; pop0 = 1'b0;
        @(negedge clock);
        vectors++;
        if (count0 !== 4'd8) begin
            miscompares++;
            $display("FAIL full_pushpop: cnt=%0d, want 8", count0);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (keycode0 !== exp[i] || irq0 !== 1'b1) begin
                miscompares++;
                $display("FAIL drain%0d: got %h irq=%b, want %h/1", i, keycode0, irq0, exp[i]);
            end
            pulse_pop0();
        end
        vectors++;
        if (count0 !== 4'd0 || irq0 !== 1'b0 || overflow0 !== 1'b1) begin
            miscompares++;
            $display("FAIL drained: cnt=%0d irq=%b ovf=%b, want 0/0/1", count0, irq0, overflow0);
        end
        clr0 = 1'b1; @(negedge clock); clr0 = 1'b0;
        vectors++;
        if (overflow0 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b, want 0", overflow0);
        end
    endtask

    task automatic test_raw();
        logic [7:0] exp [4] = '{8'hf0, 8'h1c, 8'he0, 8'h75};
        send1(8'hf0); send1(8'h1c); send1(8'he0); send1(8'h75); send1(8'hfa);
        vectors++;
        if (count1 !== 4'd4) begin
            miscompares++;
            $display("FAIL raw_count: cnt=%0d, want 4", count1);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (keycode1 !== exp[i]) begin
                miscompares++;
                $display("FAIL raw_entry%0d: got %h, want %h", i, keycode1, exp[i]);
            end
            pulse_pop1();
        end
    endtask

    task automatic test_back_to_back_reset();
        send0(8'h1c);
        // E0 75 then a byte while the 48 is still being emitted
        rx_data0 = 8'he0; rx_valid0 = 1'b1; @(negedge clock);
        rx_data0 = 8'h75; @(negedge clock);
        rx_data0 = 8'h16; @(negedge clock);
        rx_valid0 = 1'b0; @(negedge clock);
        vectors++;
        if (count0 !== 4'd3 || overflow0 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b: cnt=%0d ovf=%b, want 3/1", count0, overflow0);
        end
        send0(8'he0); send0(8'hf0);
        reset = 1'b0; @(negedge clock); reset = 1'b1;
        vectors++;
        if ({irq0, keycode0, count0, overflow0} !== {1'b0, 8'h00, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: irq=%b key=%h cnt=%0d ovf=%b, want 0/00/0/0", irq0, keycode0, count0, overflow0);
        end
        send0(8'h75);
        vectors++;
        if (count0 !== 4'd1 || keycode0 !== 8'h48) begin
            miscompares++;
            $display("FAIL after_reset: cnt=%0d key=%h, want 1/48", count0, keycode0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b1;
        test_reset();
        test_make_break();
        test_extended();
        test_filter_errors();
        test_overflow_wrap();
        test_raw();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
